// File: rtl/amo_sequencer.sv
// Multicycle sequencer for RV32A LR.W / SC.W / AMO*.W on the shared datapath.
// Owns the datapath strobes while busy and holds the single LR/SC reservation.
module amo_sequencer #(
  parameter int ADDR_W      = 32,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [4:0]        funct5,
  input  logic [ADDR_W-1:0] addr,
  input  logic              mem_ready,
  input  logic              trap_event,
  input  logic              snoop_wr,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic              misaligned,
  output logic              bus_fault,
  output logic              mem_valid,
  output logic              mem_we,
  output logic              adr_src,
  output logic              buf_addr_we,
  output logic              temp_we,
  output logic              temp_src_alu,
  output logic              wdata_from_temp,
  output logic              reg_write,
  output logic [1:0]        result_sel,
  output logic              sc_status,
  output logic [4:0]        alu_fn,
  output logic              reserved
);

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SWAP = 5'b00001;
  localparam logic [4:0] OP_LR   = 5'b00010;
  localparam logic [4:0] OP_SC   = 5'b00011;
  localparam logic [4:0] OP_XOR  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b01000;
  localparam logic [4:0] OP_AND  = 5'b01100;
  localparam logic [4:0] OP_MIN  = 5'b10000;
  localparam logic [4:0] OP_MAX  = 5'b10100;
  localparam logic [4:0] OP_MINU = 5'b11000;
  localparam logic [4:0] OP_MAXU = 5'b11100;

  localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_READ, S_WB, S_CALC, S_WRITE, S_SC_CHK, S_SC_WB, S_DONE, S_FAULT
  } state_t;

  typedef enum logic [1:0] {F_NONE, F_ILLEGAL, F_MISALIGNED, F_BUS} fault_t;

  state_t              state_q, state_d;
  fault_t              fault_q, fault_d;
  logic [4:0]          alu_fn_q, alu_fn_d;
  logic [ADDR_W-1:2]   buf_word_q, buf_word_d;
  logic [ADDR_W-1:2]   res_word_q, res_word_d;
  logic [ADDR_W-1:2]   match_word;
  logic                res_valid_q, res_valid_d;
  logic                sc_status_q, sc_status_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                tmo_hit;
  logic                lr_set;
  logic                sc_ok;
  logic                is_lr, is_sc;
  logic                unused_ok;

  function automatic logic op_legal(input logic [4:0] f);
    case (f)
      OP_ADD, OP_SWAP, OP_LR, OP_SC, OP_XOR, OP_OR, OP_AND,
      OP_MIN, OP_MAX, OP_MINU, OP_MAXU: op_legal = 1'b1;
      default:                          op_legal = 1'b0;
    endcase
  endfunction

  assign is_lr     = (alu_fn_q == OP_LR);
  assign is_sc     = (alu_fn_q == OP_SC);
  assign tmo_hit   = (MEM_TIMEOUT > 0) && (tmo_q == TMO_LAST);
  assign sc_ok     = res_valid_q && (res_word_q == buf_word_q);
  assign busy      = (state_q != S_IDLE);
  assign alu_fn    = alu_fn_q;
  assign sc_status = sc_status_q;
  assign reserved  = res_valid_q;
  // Only the word address matters for snoop matching.
  assign unused_ok = ^snoop_addr[1:0];

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d         = state_q;
    fault_d         = fault_q;
    alu_fn_d        = alu_fn_q;
    buf_word_d      = buf_word_q;
    res_word_d      = res_word_q;
    res_valid_d     = res_valid_q;
    sc_status_d     = sc_status_q;
    tmo_d           = tmo_q;
    lr_set          = 1'b0;
    done            = 1'b0;
    illegal         = 1'b0;
    misaligned      = 1'b0;
    bus_fault       = 1'b0;
    mem_valid       = 1'b0;
    mem_we          = 1'b0;
    adr_src         = 1'b0;
    buf_addr_we     = 1'b0;
    temp_we         = 1'b0;
    temp_src_alu    = 1'b0;
    wdata_from_temp = 1'b0;
    reg_write       = 1'b0;
    result_sel      = 2'd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          alu_fn_d = funct5;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        buf_addr_we = 1'b1;
        buf_word_d  = addr[ADDR_W-1:2];
        tmo_d       = '0;
        if (!op_legal(alu_fn_q)) begin
          fault_d = F_ILLEGAL;
          state_d = S_FAULT;
        end else if (addr[1:0] != 2'b00) begin
          fault_d = F_MISALIGNED;
          state_d = S_FAULT;
          // A faulting SC still consumes the reservation.
          if (is_sc) res_valid_d = 1'b0;
        end else if (is_sc) begin
          state_d = S_SC_CHK;
        end else begin
          state_d = S_READ;
        end
      end
      S_READ: begin
        mem_valid = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) begin
          temp_we = 1'b1;
          state_d = S_WB;
          if (is_lr) begin
            lr_set      = 1'b1;
            res_valid_d = 1'b1;
            res_word_d  = buf_word_q;
          end
        end else if (tmo_hit) begin
          fault_d = F_BUS;
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        state_d   = is_lr ? S_DONE : S_CALC;
      end
      S_CALC: begin
        temp_we      = 1'b1;
        temp_src_alu = 1'b1;
        tmo_d        = '0;
        state_d      = S_WRITE;
      end
      S_WRITE: begin
        mem_valid       = 1'b1;
        mem_we          = 1'b1;
        adr_src         = 1'b1;
        wdata_from_temp = !is_sc;
        if (mem_ready) begin
          state_d = is_sc ? S_SC_WB : S_DONE;
        end else if (tmo_hit) begin
          fault_d = F_BUS;
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_SC_CHK: begin
        res_valid_d = 1'b0;
        sc_status_d = !sc_ok;
        tmo_d       = '0;
        state_d     = sc_ok ? S_WRITE : S_SC_WB;
      end
      S_SC_WB: begin
        reg_write  = 1'b1;
        result_sel = 2'd1;
        state_d    = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_FAULT: begin
        done       = 1'b1;
        illegal    = (fault_q == F_ILLEGAL);
        misaligned = (fault_q == F_MISALIGNED);
        bus_fault  = (fault_q == F_BUS);
        fault_d    = F_NONE;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Clearing events beat a same-cycle LR; a snoop is matched against the word LR is claiming.
    match_word = lr_set ? buf_word_q : res_word_q;
    if (trap_event || (snoop_wr && (snoop_addr[ADDR_W-1:2] == match_word))) begin
      res_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      fault_q     <= F_NONE;
      alu_fn_q    <= '0;
      buf_word_q  <= '0;
      res_word_q  <= '0;
      res_valid_q <= 1'b0;
      sc_status_q <= 1'b0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      fault_q     <= fault_d;
      alu_fn_q    <= alu_fn_d;
      buf_word_q  <= buf_word_d;
      res_word_q  <= res_word_d;
      res_valid_q <= res_valid_d;
      sc_status_q <= sc_status_d;
      tmo_q       <= tmo_d;
    end
  end

endmodule

// File: tb/tb_amo_sequencer.sv
// Self-checking bench for amo_sequencer: a behavioural datapath/memory environment
// driven by the DUT strobes, compared against an instruction-level reference model.
module tb_amo_sequencer;

  localparam int TMO = 4;
  localparam logic [4:0] F_ADD  = 5'b00000, F_SWAP = 5'b00001, F_LR   = 5'b00010,
                         F_SC   = 5'b00011, F_XOR  = 5'b00100, F_OR   = 5'b01000,
                         F_AND  = 5'b01100, F_MIN  = 5'b10000, F_MAX  = 5'b10100,
                         F_MINU = 5'b11000, F_MAXU = 5'b11100;

  logic        clk, resetn, start, mem_ready, trap_event, snoop_wr;
  logic [4:0]  funct5;
  logic [31:0] addr, snoop_addr;
  logic        busy, done, illegal, misaligned, bus_fault, mem_valid, mem_we, adr_src;
  logic        buf_addr_we, temp_we, temp_src_alu, wdata_from_temp, reg_write, sc_status, reserved;
  logic [1:0]  result_sel;
  logic [4:0]  alu_fn;

  amo_sequencer #(.ADDR_W(32), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn), .start(start), .funct5(funct5), .addr(addr),
    .mem_ready(mem_ready), .trap_event(trap_event), .snoop_wr(snoop_wr),
    .snoop_addr(snoop_addr), .busy(busy), .done(done), .illegal(illegal),
    .misaligned(misaligned), .bus_fault(bus_fault), .mem_valid(mem_valid),
    .mem_we(mem_we), .adr_src(adr_src), .buf_addr_we(buf_addr_we), .temp_we(temp_we),
    .temp_src_alu(temp_src_alu), .wdata_from_temp(wdata_from_temp),
    .reg_write(reg_write), .result_sel(result_sel), .sc_status(sc_status),
    .alu_fn(alu_fn), .reserved(reserved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, n_fail = 0, op_no = 0;

  logic [31:0] mem_ref [256];
  logic [31:0] mem_env [256];
  logic [31:0] temp_env;
  bit          ref_res_v;
  logic [31:0] ref_res_a;
  logic [31:0] pool [4] = '{32'h100, 32'h104, 32'h108, 32'h200};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL op%0d %s: observed %h expected %h", op_no, tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [4:0] f);
    return f inside {F_ADD, F_SWAP, F_LR, F_SC, F_XOR, F_OR, F_AND, F_MIN, F_MAX, F_MINU, F_MAXU};
  endfunction

  function automatic logic [31:0] amo_f(input logic [4:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      F_ADD:   return a + b;
      F_SWAP:  return b;
      F_XOR:   return a ^ b;
      F_AND:   return a & b;
      F_OR:    return a | b;
      F_MIN:   return ($signed(a) < $signed(b)) ? a : b;
      F_MAX:   return ($signed(a) > $signed(b)) ? a : b;
      F_MINU:  return (a < b) ? a : b;
      F_MAXU:  return (a > b) ? a : b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] out_vec();
    return {10'b0, busy, done, illegal, misaligned, bus_fault, mem_valid, mem_we, adr_src,
            buf_addr_we, temp_we, temp_src_alu, wdata_from_temp, reg_write, result_sel,
            sc_status, alu_fn, reserved};
  endfunction

  // One instruction: rw/ww are mem_ready wait cycles on read/write (>= TMO means never ready).
  task automatic run_op(input logic [4:0] fn, input logic [31:0] a, input logic [31:0] rs2,
                        input int rw, input int ww, input bit restart);
    int idx, e_lat, e_regw, e_mv, e_wr, lat, regw, mv, wr, bad_adr, baw, busy_gap, rcnt, wcnt, cyc;
    bit e_ill, e_mis, e_bf, g_ill, g_mis, g_bf, g_mv_done, seen, succ;
    logic [31:0] old, e_rd, rd_env, temp_next;
    op_no++;
    idx = int'(a[9:2]);
    old = mem_ref[idx];
    e_lat = 0; e_regw = 0; e_mv = 0; e_wr = 0; e_rd = 32'hDEADBEEF;
    e_ill = 0; e_mis = 0; e_bf = 0;
    if (!is_legal(fn)) begin
      e_lat = 2; e_ill = 1;
    end else if (a[1:0] != 2'b00) begin
      e_lat = 2; e_mis = 1;
      if (fn == F_SC) ref_res_v = 0;
    end else if (fn == F_LR) begin
      if (rw >= TMO) begin e_lat = 2 + TMO; e_bf = 1; e_mv = TMO; end
      else begin
        e_lat = 4 + rw; e_rd = old; e_regw = 1; e_mv = rw + 1;
        ref_res_v = 1; ref_res_a = a;
      end
    end else if (fn == F_SC) begin
      succ = ref_res_v && (ref_res_a == a);
      ref_res_v = 0;
      if (!succ) begin e_lat = 4; e_regw = 1; e_rd = 32'd1; end
      else if (ww >= TMO) begin e_lat = 3 + TMO; e_bf = 1; e_mv = TMO; end
      else begin
        e_lat = 5 + ww; e_regw = 1; e_rd = 32'd0; e_mv = ww + 1; e_wr = 1;
        mem_ref[idx] = rs2;
      end
    end else begin
      if (rw >= TMO) begin e_lat = 2 + TMO; e_bf = 1; e_mv = TMO; end
      else if (ww >= TMO) begin
        e_lat = 5 + rw + TMO; e_bf = 1; e_regw = 1; e_rd = old; e_mv = rw + 1 + TMO;
      end else begin
        e_lat = 6 + rw + ww; e_regw = 1; e_rd = old; e_mv = rw + ww + 2; e_wr = 1;
        mem_ref[idx] = amo_f(fn, old, rs2);
      end
    end

    lat = -1; regw = 0; mv = 0; wr = 0; bad_adr = 0; baw = 0; busy_gap = 0;
    rcnt = 0; wcnt = 0; seen = 0; g_ill = 0; g_mis = 0; g_bf = 0; g_mv_done = 0;
    rd_env = 32'hDEADBEEF;
    start = 1; funct5 = fn; addr = a;
    @(posedge clk); #1;
    funct5 = ~fn;
    cyc = 1;
    while (!seen && cyc < 40) begin
      start  = restart && (cyc == 2);
      funct5 = 5'b11111;
      mem_ready = 0;
      if (mem_valid && !mem_we) begin if (rcnt == rw) mem_ready = 1; else rcnt++; end
      if (mem_valid && mem_we)  begin if (wcnt == ww) mem_ready = 1; else wcnt++; end
      #1;
      temp_next = temp_env;
      if (!busy) busy_gap++;
      if (mem_valid) mv++;
      if (mem_valid && !adr_src) bad_adr++;
      if (buf_addr_we) baw++;
      if (temp_we) temp_next = temp_src_alu ? amo_f(alu_fn, temp_env, rs2) : mem_env[idx];
      if (mem_valid && mem_we && mem_ready) begin
        mem_env[idx] = wdata_from_temp ? temp_env : rs2;
        wr++;
      end
      if (reg_write) begin
        regw++;
        rd_env = (result_sel == 2'd1) ? {31'b0, sc_status} : temp_env;
      end
      if (done) begin
        seen = 1; lat = cyc; g_ill = illegal; g_mis = misaligned; g_bf = bus_fault;
        g_mv_done = mem_valid;
      end
      @(posedge clk); #1;
      temp_env = temp_next;
      cyc++;
    end
    start = 0; mem_ready = 0;

    check("latency", 32'(lat), 32'(e_lat));
    check("illegal", 32'(g_ill), 32'(e_ill));
    check("misaligned", 32'(g_mis), 32'(e_mis));
    check("bus_fault", 32'(g_bf), 32'(e_bf));
    check("mem_valid_cycles", 32'(mv), 32'(e_mv));
    check("mem_writes", 32'(wr), 32'(e_wr));
    check("reg_writes", 32'(regw), 32'(e_regw));
    check("rd_value", rd_env, e_rd);
    check("mem_word", mem_env[idx], mem_ref[idx]);
    check("reserved", 32'(reserved), 32'(ref_res_v));
    check("busy_gap", 32'(busy_gap), 32'd0);
    check("adr_src", 32'(bad_adr), 32'd0);
    check("buf_addr_we", 32'(baw), 32'd1);
    check("mem_valid_at_done", 32'(g_mv_done), 32'd0);
    check("idle_after_done", {30'b0, busy, done}, 32'd0);
  endtask

  task automatic pulse_event(input bit is_trap, input logic [31:0] sa);
    if (is_trap) begin
      trap_event = 1; ref_res_v = 0;
    end else begin
      snoop_wr = 1; snoop_addr = sa;
      if (sa[31:2] == ref_res_a[31:2]) ref_res_v = 0;
    end
    @(posedge clk); #1;
    trap_event = 0; snoop_wr = 0;
    check("reserved_after_event", 32'(reserved), 32'(ref_res_v));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0]  fn;
    logic [31:0] a;
    int r;
    resetn = 0; start = 0; funct5 = 0; addr = 0; mem_ready = 0;
    trap_event = 0; snoop_wr = 0; snoop_addr = 0; temp_env = 0;
    ref_res_v = 0; ref_res_a = 0;
    for (int i = 0; i < 256; i++) begin
      mem_ref[i] = $urandom;
      mem_env[i] = mem_ref[i];
    end
    #1;
    check("reset_outputs", out_vec(), 32'd0);
    repeat (2) @(posedge clk);
    #2 resetn = 1;
    @(posedge clk); #1;
    check("post_reset_outputs", out_vec(), 32'd0);

    // AMOADD 0x100: mem 5 + rs2 3
    mem_ref[64] = 32'd5; mem_env[64] = 32'd5;
    run_op(F_ADD, 32'h100, 32'd3, 0, 0, 0);
    check("amoadd_mem_is_8", mem_env[64], 32'd8);

    // LR / SC success / SC fail
    run_op(F_LR, 32'h200, 32'd0, 0, 0, 0);
    check("lr_sets_reserved", 32'(reserved), 32'd1);
    run_op(F_SC, 32'h200, 32'hCAFE0001, 0, 0, 0);
    check("sc_status_ok", 32'(sc_status), 32'd0);
    check("sc_mem", mem_env[128], 32'hCAFE0001);
    run_op(F_SC, 32'h200, 32'h12345678, 0, 0, 0);
    check("sc_status_fail", 32'(sc_status), 32'd1);

    // Reservation lost to snoop, then to trap
    run_op(F_LR, 32'h200, 32'd0, 1, 0, 0);
    pulse_event(0, 32'h202);
    run_op(F_SC, 32'h200, 32'h1, 0, 0, 0);
    check("sc_after_snoop", 32'(sc_status), 32'd1);
    run_op(F_LR, 32'h200, 32'd0, 0, 0, 0);
    pulse_event(1, 32'h0);
    run_op(F_SC, 32'h200, 32'h1, 0, 0, 0);
    check("sc_after_trap", 32'(sc_status), 32'd1);

    // Faults: misaligned, illegal, bus timeout
    run_op(F_SWAP, 32'h101, 32'h55, 0, 0, 0);
    run_op(5'b11111, 32'h104, 32'h55, 0, 0, 0);
    run_op(F_ADD, 32'h108, 32'h7, 99, 0, 0);

    // AMOMAXU with 3-cycle waits and a start pulse while busy
    mem_ref[65] = 32'hFFFFFFFF; mem_env[65] = 32'hFFFFFFFF;
    run_op(F_MAXU, 32'h104, 32'd1, 3, 3, 1);
    check("maxu_mem", mem_env[65], 32'hFFFFFFFF);

    // Reset while WRITE is waiting on mem_ready
    run_op(F_LR, 32'h104, 32'd0, 0, 0, 0);
    begin : reset_mid_write
      int k;
      k = 0;
      start = 1; funct5 = F_ADD; addr = 32'h108;
      @(posedge clk); #1;
      start = 0;
      while (!(mem_valid && mem_we) && k < 20) begin
        mem_ready = mem_valid && !mem_we;
        @(posedge clk); #1;
        k++;
      end
      mem_ready = 0;
      check("reached_write", 32'(mem_we), 32'd1);
      resetn = 0; ref_res_v = 0;
      #1;
      check("reset_mid_write_outputs", out_vec(), 32'd0);
      @(posedge clk); #2;
      resetn = 1;
      @(posedge clk); #1;
      check("after_reset_idle", out_vec(), 32'd0);
      check("no_write_on_reset", mem_env[66], mem_ref[66]);
    end

    // Randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 9);
      if (r < 2) fn = F_LR;
      else if (r < 4) fn = F_SC;
      else if (r == 4) begin
        fn = 5'($urandom_range(0, 31));
        while (is_legal(fn)) fn = 5'($urandom_range(0, 31));
      end else begin
        case ($urandom_range(0, 8))
          0: fn = F_ADD;  1: fn = F_SWAP; 2: fn = F_XOR;
          3: fn = F_AND;  4: fn = F_OR;   5: fn = F_MIN;
          6: fn = F_MAX;  7: fn = F_MINU; default: fn = F_MAXU;
        endcase
      end
      a = pool[$urandom_range(0, 3)];
      if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
      run_op(fn, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      r = $urandom_range(0, 3);
      if (r == 0) pulse_event(1, 32'h0);
      else if (r == 1) pulse_event(0, pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
